// File: rtl/decode_execute_latch_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_latch_if
// Description : Bundle of decode-side (*_next) and execute-side (*_ex)
//               signals around the ID/EX pipeline register, together with
//               the advance / stall / flush control and the hazard output.
//               master : the upstream/environment side (drives *_next, ihit,
//                        stall_in, flush; observes *_ex, valid_ex,
//                        hazard_stall)
//               slave  : the ID/EX latch itself
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_execute_latch_if #(
  parameter int WORD_W  = 32,
  parameter int REG_W   = 5,
  parameter int SHAMT_W = 5
);
  // Pipeline control
  logic               ihit;
  logic               stall_in;
  logic               flush;

  // Decode-side inputs
  logic [WORD_W-1:0]  nPC_next;
  logic [REG_W-1:0]   rs_next;
  logic [REG_W-1:0]   rt_next;
  logic               rt_used_next;
  logic [REG_W-1:0]   regDst_next;
  logic               regWr_next;
  logic               dREN_next;
  logic               dWEN_next;
  logic               halt_next;
  logic [1:0]         regSel_next;
  logic [3:0]         ALUOp_next;
  logic [1:0]         PCSrc_next;
  logic [1:0]         ALUSrc_next;
  logic [WORD_W-1:0]  rdat1_next;
  logic [WORD_W-1:0]  rdat2_next;
  logic [WORD_W-1:0]  imm_next;
  logic [SHAMT_W-1:0] shamt_next;

  // Execute-side outputs
  logic [WORD_W-1:0]  nPC_ex;
  logic [REG_W-1:0]   rs_ex;
  logic [REG_W-1:0]   rt_ex;
  logic [REG_W-1:0]   regDst_ex;
  logic               regWr_ex;
  logic               dREN_ex;
  logic               dWEN_ex;
  logic               halt_ex;
  logic [1:0]         regSel_ex;
  logic [3:0]         ALUOp_ex;
  logic [1:0]         PCSrc_ex;
  logic [1:0]         ALUSrc_ex;
  logic [WORD_W-1:0]  rdat1_ex;
  logic [WORD_W-1:0]  rdat2_ex;
  logic [WORD_W-1:0]  imm_ex;
  logic [SHAMT_W-1:0] shamt_ex;
  logic               valid_ex;
  logic               hazard_stall;

  modport master (
    output ihit, stall_in, flush,
    output nPC_next, rs_next, rt_next, rt_used_next, regDst_next,
    output regWr_next, dREN_next, dWEN_next, halt_next, regSel_next,
    output ALUOp_next, PCSrc_next, ALUSrc_next,
    output rdat1_next, rdat2_next, imm_next, shamt_next,
    input  nPC_ex, rs_ex, rt_ex, regDst_ex, regWr_ex, dREN_ex, dWEN_ex,
    input  halt_ex, regSel_ex, ALUOp_ex, PCSrc_ex, ALUSrc_ex,
    input  rdat1_ex, rdat2_ex, imm_ex, shamt_ex, valid_ex, hazard_stall
  );

  modport slave (
    input  ihit, stall_in, flush,
    input  nPC_next, rs_next, rt_next, rt_used_next, regDst_next,
    input  regWr_next, dREN_next, dWEN_next, halt_next, regSel_next,
    input  ALUOp_next, PCSrc_next, ALUSrc_next,
    input  rdat1_next, rdat2_next, imm_next, shamt_next,
    output nPC_ex, rs_ex, rt_ex, regDst_ex, regWr_ex, dREN_ex, dWEN_ex,
    output halt_ex, regSel_ex, ALUOp_ex, PCSrc_ex, ALUSrc_ex,
    output rdat1_ex, rdat2_ex, imm_ex, shamt_ex, valid_ex, hazard_stall
  );
endinterface
`default_nettype wire

// File: rtl/decode_execute_latch.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_latch
// Description : ID/EX pipeline register. Captures the decode stage's *_next
//               values on every advancing edge (ihit & ~stall_in), detects
//               load-use hazards against the instruction held in EX (one
//               bubble + hazard_stall to hold fetch/decode) and squashes the
//               decode instruction on flush. A flush seen while frozen is
//               remembered and applied on the next advancing edge.
// Ports       : CLK, RST (async, active-high)
//               bus          - decode_execute_latch_if.slave
//               bubble_cnt   - 16-bit saturating bubble counter (optional)
// Options     : ID_EX_BUBBLE_CNT_EN - when defined, adds the bubble_cnt
//               output counting every advancing edge that inserts a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_execute_latch #(
  parameter int WORD_W  = 32,
  parameter int REG_W   = 5,
  parameter int SHAMT_W = 5
) (
  input  logic                         CLK,
  input  logic                         RST,
  decode_execute_latch_if.slave        bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]                  bubble_cnt
`endif
);

  typedef struct packed {
    logic [WORD_W-1:0]  nPC;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   regDst;
    logic               regWr;
    logic               dREN;
    logic               dWEN;
    logic               halt;
    logic [1:0]         regSel;
    logic [3:0]         ALUOp;
    logic [1:0]         PCSrc;
    logic [1:0]         ALUSrc;
    logic [WORD_W-1:0]  rdat1;
    logic [WORD_W-1:0]  rdat2;
    logic [WORD_W-1:0]  imm;
    logic [SHAMT_W-1:0] shamt;
  } ex_t;

  ex_t  ex_q, ex_d, ex_cap;
  logic valid_q, valid_d;
  logic flush_pend_q, flush_pend_d;

  logic adv;
  logic flush_eff;
  logic lu;

  assign adv       = bus.ihit & ~bus.stall_in;
  assign flush_eff = bus.flush | flush_pend_q;

  // Load-use: EX holds a load whose destination (non-zero) is read by the
  // instruction currently being decoded.
  assign lu = valid_q & ex_q.dREN & ex_q.regWr & (ex_q.regDst != '0) &
              ((ex_q.regDst == bus.rs_next) |
               (bus.rt_used_next & (ex_q.regDst == bus.rt_next)));

  // The decode instruction is discarded on flush, so no stall is needed.
  assign bus.hazard_stall = lu & ~flush_eff;

  always_comb begin
    ex_cap.nPC    = bus.nPC_next;
    ex_cap.rs     = bus.rs_next;
    ex_cap.rt     = bus.rt_next;
    ex_cap.regDst = bus.regDst_next;
    ex_cap.regWr  = bus.regWr_next;
    ex_cap.dREN   = bus.dREN_next;
    ex_cap.dWEN   = bus.dWEN_next;
    ex_cap.halt   = bus.halt_next;
    ex_cap.regSel = bus.regSel_next;
    ex_cap.ALUOp  = bus.ALUOp_next;
    ex_cap.PCSrc  = bus.PCSrc_next;
    ex_cap.ALUSrc = bus.ALUSrc_next;
    ex_cap.rdat1  = bus.rdat1_next;
    ex_cap.rdat2  = bus.rdat2_next;
    ex_cap.imm    = bus.imm_next;
    ex_cap.shamt  = bus.shamt_next;
  end

  always_comb begin
    ex_d         = ex_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    if (adv) begin
      // Any pending flush is consumed by this edge whichever branch wins.
      flush_pend_d = 1'b0;
      if (flush_eff || lu) begin
        ex_d    = '0;
        valid_d = 1'b0;
      end else begin
        ex_d    = ex_cap;
        valid_d = 1'b1;
      end
    end else if (bus.flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q         <= '0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.nPC_ex    = ex_q.nPC;
  assign bus.rs_ex     = ex_q.rs;
  assign bus.rt_ex     = ex_q.rt;
  assign bus.regDst_ex = ex_q.regDst;
  assign bus.regWr_ex  = ex_q.regWr;
  assign bus.dREN_ex   = ex_q.dREN;
  assign bus.dWEN_ex   = ex_q.dWEN;
  assign bus.halt_ex   = ex_q.halt;
  assign bus.regSel_ex = ex_q.regSel;
  assign bus.ALUOp_ex  = ex_q.ALUOp;
  assign bus.PCSrc_ex  = ex_q.PCSrc;
  assign bus.ALUSrc_ex = ex_q.ALUSrc;
  assign bus.rdat1_ex  = ex_q.rdat1;
  assign bus.rdat2_ex  = ex_q.rdat2;
  assign bus.imm_ex    = ex_q.imm;
  assign bus.shamt_ex  = ex_q.shamt;
  assign bus.valid_ex  = valid_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (adv && (flush_eff || lu) && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt_q <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire
